// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch: captures decode outputs with writeback bypass, detects
// load-use hazards, inserts bubbles on hazards/flushes and holds on EX back-pressure.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [4:0]        write_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [4:0]        wb_write_reg,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_out,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       stall_cycles
);

  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [DATA_W-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;
  logic              hz;

  // The register file commits at the edge, so a same-cycle write must be forwarded here.
  function automatic logic [DATA_W-1:0] op_sel(input logic [4:0]        rr,
                                               input logic [DATA_W-1:0] rf,
                                               input logic              wbw,
                                               input logic [4:0]        wbr,
                                               input logic [DATA_W-1:0] wbd);
    if (rr == 5'd0)
      return '0;
    else if (wbw && (wbr == rr))
      return wbd;
    else
      return rf;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    hz = valid_q && mr_q && (rd_q != 5'd0) && in_valid &&
         ((read_reg1 == rd_q) || (read_reg2 == rd_q));
    stall_out = !flush && (hz || ex_stall);

    valid_d        = valid_q;
    rw_d           = rw_q;
    mr_d           = mr_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    data1_d        = data1_q;
    data2_d        = data2_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    ctrl_d         = ctrl_q;
    stall_cycles_d = stall_cycles_q;

    if (flush || (!ex_stall && hz)) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      data1_d = '0;
      data2_d = '0;
      pc_d    = '0;
      imm_d   = '0;
      ctrl_d  = '0;
      if (!flush)
        stall_cycles_d = sat_inc(stall_cycles_q);
    end else if (ex_stall) begin
      // A held instruction keeps its operands fresh against writebacks.
      if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs1_q))
        data1_d = wb_write_data;
      if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs2_q))
        data2_d = wb_write_data;
    end else begin
      valid_d = in_valid;
      rw_d    = in_valid && reg_write;
      mr_d    = in_valid && mem_read;
      rs1_d   = read_reg1;
      rs2_d   = read_reg2;
      rd_d    = write_reg;
      data1_d = op_sel(read_reg1, read_data1, wb_reg_write, wb_write_reg, wb_write_data);
      data2_d = op_sel(read_reg2, read_data2, wb_reg_write, wb_write_reg, wb_write_data);
      pc_d    = pc;
      imm_d   = imm;
      ctrl_d  = ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      rw_q           <= 1'b0;
      mr_q           <= 1'b0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      data1_q        <= '0;
      data2_q        <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      ctrl_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      valid_q        <= valid_d;
      rw_q           <= rw_d;
      mr_q           <= mr_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      data1_q        <= data1_d;
      data2_q        <= data2_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      ctrl_q         <= ctrl_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = rw_q;
  assign ex_mem_read  = mr_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_data1     = data1_q;
  assign ex_data2     = data2_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed expected
// EX state per cycle, a monitor pops and compares after each rising edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  read_reg1, read_reg2, write_reg, wb_write_reg;
  logic [31:0] read_data1, read_data2, pc, imm, wb_write_data;
  logic        reg_write, mem_read, wb_reg_write, flush, ex_stall;
  logic [7:0]  ctrl;
  logic        stall_out, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_data1, ex_data2, ex_pc, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v, rw, mr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, pc, imm;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .reg_write(reg_write), .mem_read(mem_read),
    .pc(pc), .imm(imm), .ctrl(ctrl),
    .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write), .wb_write_data(wb_write_data),
    .flush(flush), .ex_stall(ex_stall), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic rw, input logic mr,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] p, input logic [31:0] im,
                              input logic [7:0] c, input logic [15:0] cnt);
    exp_t e;
    e.v = v; e.rw = rw; e.mr = mr; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.pc = p; e.imm = im; e.ctrl = c; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bub(input logic [15:0] cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ex_valid", ex_valid, e.v);
      chk("ex_reg_write", ex_reg_write, e.rw);
      chk("ex_mem_read", ex_mem_read, e.mr);
      chk("ex_rs1", ex_rs1, e.rs1);
      chk("ex_rs2", ex_rs2, e.rs2);
      chk("ex_rd", ex_rd, e.rd);
      chk("ex_data1", ex_data1, e.d1);
      chk("ex_data2", ex_data2, e.d2);
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_ctrl", ex_ctrl, e.ctrl);
      chk("stall_cycles", stall_cycles, e.cnt);
    end
  end

  task automatic idle();
    rst_n = 1'b1; in_valid = 0; read_reg1 = 0; read_reg2 = 0; read_data1 = 0; read_data2 = 0;
    write_reg = 0; reg_write = 0; mem_read = 0; pc = 0; imm = 0; ctrl = 0;
    wb_write_reg = 0; wb_reg_write = 0; wb_write_data = 0; flush = 0; ex_stall = 0;
  endtask

  task automatic rnd_inputs();
    in_valid = 1'($urandom); read_reg1 = 5'($urandom); read_reg2 = 5'($urandom);
    read_data1 = $urandom; read_data2 = $urandom; write_reg = 5'($urandom);
    reg_write = 1'($urandom); mem_read = 1'($urandom); pc = $urandom; imm = $urandom;
    ctrl = 8'($urandom); wb_write_reg = 5'($urandom); wb_reg_write = 1'($urandom);
    wb_write_data = $urandom; flush = 1'($urandom); ex_stall = 1'b0;
  endtask

  task automatic step(input logic chk_st, input logic st_exp, input exp_t e);
    #1;
    if (chk_st) chk("stall_out", stall_out, st_exp);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_use(input logic [15:0] cnt_before, input logic [15:0] cnt_after);
    idle();
    in_valid = 1; mem_read = 1; reg_write = 1; write_reg = 7; pc = 32'h300; ctrl = 8'h11;
    step(1, 0, mk(1, 1, 1, 0, 0, 7, 0, 0, 32'h300, 0, 8'h11, cnt_before));
    idle();
    in_valid = 1; read_reg2 = 7; read_data2 = 32'h70; reg_write = 1; write_reg = 8; pc = 32'h304;
    step(1, 1, bub(cnt_after));
  endtask

  initial begin
    idle();
    // Reset with random inputs
    rst_n = 0; rnd_inputs();
    step(0, 0, bub(0));
    rst_n = 0; rnd_inputs();
    step(1, 0, bub(0));

    idle();
    in_valid = 1; read_reg1 = 3; read_data1 = 32'h55; read_data2 = 32'h77;
    write_reg = 2; reg_write = 1; pc = 32'h100; imm = 4; ctrl = 8'h5A;
    step(1, 0, mk(1, 1, 0, 3, 0, 2, 32'h55, 0, 32'h100, 4, 8'h5A, 0));

    // Writeback bypass, then x0 never bypassed
    read_reg1 = 5; read_data1 = 32'h11; read_reg2 = 6; read_data2 = 32'h22;
    wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'hAA; pc = 32'h104;
    step(1, 0, mk(1, 1, 0, 5, 6, 2, 32'hAA, 32'h22, 32'h104, 4, 8'h5A, 0));
    read_reg1 = 0; wb_write_reg = 0; pc = 32'h108;
    step(1, 0, mk(1, 1, 0, 0, 6, 2, 0, 32'h22, 32'h108, 4, 8'h5A, 0));

    // A load to x0 is never a hazard source
    idle();
    in_valid = 1; mem_read = 1; reg_write = 1; write_reg = 0; pc = 32'h10C;
    step(1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 32'h10C, 0, 0, 0));
    idle();
    in_valid = 1; reg_write = 1; write_reg = 3; pc = 32'h110;
    step(1, 0, mk(1, 1, 0, 0, 0, 3, 0, 0, 32'h110, 0, 0, 0));

    // Load-use: one bubble then the held instruction loads
    idle();
    in_valid = 1; mem_read = 1; reg_write = 1; write_reg = 7;
    read_reg1 = 1; read_data1 = 32'h10; read_reg2 = 2; read_data2 = 32'h20; pc = 32'h114;
    step(1, 0, mk(1, 1, 1, 1, 2, 7, 32'h10, 32'h20, 32'h114, 0, 0, 0));
    idle();
    in_valid = 1; reg_write = 1; write_reg = 8;
    read_reg1 = 3; read_data1 = 32'h30; read_reg2 = 7; read_data2 = 32'h70; pc = 32'h118;
    step(1, 1, bub(1));
    step(1, 0, mk(1, 1, 0, 3, 7, 8, 32'h30, 32'h70, 32'h118, 0, 0, 1));

    // Flush beats a pending hazard and ex_stall
    idle();
    in_valid = 1; mem_read = 1; reg_write = 1; write_reg = 9; pc = 32'h120; ctrl = 8'h22;
    step(1, 0, mk(1, 1, 1, 0, 0, 9, 0, 0, 32'h120, 0, 8'h22, 1));
    idle();
    in_valid = 1; read_reg1 = 9; read_data1 = 32'h99; ex_stall = 1; flush = 1;
    step(1, 0, bub(1));

    // Hold with writeback refresh of a held operand
    idle();
    in_valid = 1; read_reg1 = 9; read_data1 = 32'h1; read_reg2 = 4; read_data2 = 32'h44;
    write_reg = 10; reg_write = 1; pc = 32'h200; imm = 8; ctrl = 8'h33;
    step(1, 0, mk(1, 1, 0, 9, 4, 10, 32'h1, 32'h44, 32'h200, 8, 8'h33, 1));
    read_reg1 = 11; read_data1 = 32'hBB; read_reg2 = 12; read_data2 = 32'hCC;
    write_reg = 13; pc = 32'h204; imm = 32'hC; ctrl = 8'h44; ex_stall = 1;
    step(1, 1, mk(1, 1, 0, 9, 4, 10, 32'h1, 32'h44, 32'h200, 8, 8'h33, 1));
    wb_reg_write = 1; wb_write_reg = 9; wb_write_data = 32'h99;
    step(1, 1, mk(1, 1, 0, 9, 4, 10, 32'h99, 32'h44, 32'h200, 8, 8'h33, 1));
    wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    step(1, 1, mk(1, 1, 0, 9, 4, 10, 32'h99, 32'h44, 32'h200, 8, 8'h33, 1));
    ex_stall = 0;
    step(1, 0, mk(1, 1, 0, 11, 12, 13, 32'hBB, 32'hCC, 32'h204, 32'hC, 8'h44, 1));

    // Reset in the middle of a hazard
    idle();
    in_valid = 1; mem_read = 1; reg_write = 1; write_reg = 5; pc = 32'h280;
    step(1, 0, mk(1, 1, 1, 0, 0, 5, 0, 0, 32'h280, 0, 0, 1));
    idle();
    in_valid = 1; read_reg1 = 5; rst_n = 0;
    step(1, 1, bub(0));

    // Counting bubbles, then saturation near the top of the range
    for (int i = 0; i < 20; i++) load_use(16'(i), 16'(i + 1));
    idle();
    force dut.stall_cycles_q = 16'hFFFD;
    #1;
    release dut.stall_cycles_q;
    load_use(16'hFFFD, 16'hFFFE);
    load_use(16'hFFFE, 16'hFFFF);
    load_use(16'hFFFF, 16'hFFFF);
    load_use(16'hFFFF, 16'hFFFF);
    idle();
    rst_n = 0;
    step(1, 0, bub(0));

    idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
